uart_receiver: RTL
==================

Name: uart_receiver

Overview:
UART serial-to-parallel receiver; the receive-side counterpart of the team's oversampled UART transmitter on the same link. Samples the asynchronous rx line on a shared oversample tick (baud × OVERSAMPLE), validates the start bit at mid-bit, and shifts in data bits LSB first. Checks the stop bit and presents each good byte with a one-cycle valid strobe to the host/command-decoder logic.

Parameters:
UART_BITS_TRANSFERED, 8, data bits per frame (no parity, 1 stop bit)
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and ≥4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
baud_tick  input  1  oversample strobe, one clk wide, OVERSAMPLE per bit
rx  input  1  serial line, asynchronous, idle high
message  output  UART_BITS_TRANSFERED  last correctly received byte
valid  output  1  one-clk pulse: message updated with a new good frame
frame_error  output  1  one-clk pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst asynchronous, active-high; clock clk): state IDLE, message=0, valid=0, frame_error=0, busy=0, 2-FF rx synchronizer=1, armed=0, counters=0, shift register=0. Reset mid-frame aborts the frame with no pulse.
- rx passes through a 2-FF synchronizer (rx_sync). All decisions use rx_sync only.
- State and counter updates occur only on clk edges with baud_tick=1. valid/frame_error are cleared on every clk edge unless set in that cycle, so each is exactly one clk wide.
- IDLE: on baud_tick, rx_sync=1 sets armed=1. If armed=1 and rx_sync=0: go to START, tick_count=OVERSAMPLE/2-1.
- START: on baud_tick with tick_count≠0, decrement. At tick_count=0 (mid start bit): if rx_sync=0, go to DATA with tick_count=OVERSAMPLE-1 and bit_idx=0. Otherwise it is a glitch: return to IDLE with no pulse, armed kept 1.
- DATA: on baud_tick, decrement tick_count. At 0, shift_reg[bit_idx]<=rx_sync (LSB first) and reload tick_count=OVERSAMPLE-1. If bit_idx=UART_BITS_TRANSFERED-1, go to STOP; else increment bit_idx.
- STOP: at tick_count=0 (mid stop bit):
  - rx_sync=1: message<=shift_reg, valid=1, go to IDLE with armed=1.
  - rx_sync=0: frame_error=1, message unchanged, go to IDLE with armed=0. The next start is ignored until the line has been seen high (break/line-stuck protection).
- The return to IDLE at mid stop bit permits back-to-back frames from a transmitter with exactly one stop bit.
- Sample points: start edge is detected within 1 baud_tick + 2 clk of the true edge. The data bit k sample lands OVERSAMPLE/2 + (k+1)·OVERSAMPLE ticks after detection. valid rises in the clk cycle after the baud_tick that samples the stop bit.
- baud_tick held low freezes the state machine; rx activity is ignored except through the synchronizer.
- busy is combinational: state≠IDLE.
- message is held between frames and never changes on a glitch, framing error, or aborted frame.

Test Plan:
1. Loopback from the UART transmitter (same OVERSAMPLE, shared baud_tick), send 0xA5 -> one valid pulse, message=0xA5, frame_error never high, busy low after the stop sample.
2. rx driven low for 3 baud_ticks then high, with OVERSAMPLE=16 -> START aborts at mid-sample, no valid, no frame_error, busy back to 0, message unchanged.
3. Frame 0x3C with the stop bit forced 0, then rx held low for 40 ticks, then high, then a good 0x5A -> one frame_error pulse, message stays at its prior value, no frame started while low, then valid with message=0x5A.
4. Back-to-back 0x00 then 0xFF, one stop bit each, no idle gap -> two valid pulses, message=0x00 then 0xFF, no frame_error.
5. rst asserted after data bit 3 of 0x81 -> immediately busy=0, message=0, valid=0. After release, rx high for one bit, then 0x81 -> valid with message=0x81.
6. baud_tick held low for 100 clk mid-frame while rx is stable, then resumed -> frame completes correctly (0x6E) with no extra or missing bits.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receiver: oversample strobe and serial line in,
// received byte with its valid/frame-error strobes and busy flag out.
interface uart_receiver_if #(
    parameter int UART_BITS_TRANSFERED = 8
);
    logic                            baud_tick;
    logic                            rx;
    logic [UART_BITS_TRANSFERED-1:0] message;
    logic                            valid;
    logic                            frame_error;
    logic                            busy;

    modport master (
        output baud_tick, rx,
        input  message, valid, frame_error, busy
    );

    modport slave (
        input  baud_tick, rx,
        output message, valid, frame_error, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: mid-bit start validation, LSB-first data capture,
// stop-bit check with one-clk valid / frame_error strobes.
module uart_receiver #(
    parameter int UART_BITS_TRANSFERED = 8,
    parameter int OVERSAMPLE           = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (UART_BITS_TRANSFERED > 1) ? $clog2(UART_BITS_TRANSFERED) : 1;
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_BITS_TRANSFERED - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                          state_q, state_d;
    logic                            rx_meta_q, rx_sync_q;
    logic                            armed_q, armed_d;
    logic [TW-1:0]                   tick_q, tick_d;
    logic [BW-1:0]                   bit_q, bit_d;
    logic [UART_BITS_TRANSFERED-1:0] shift_q, shift_d;
    logic [UART_BITS_TRANSFERED-1:0] message_q, message_d;
    logic                            valid_q, valid_d;
    logic                            ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            armed_q   <= 1'b0;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            message_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            message_q <= message_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        message_d = message_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        if (bus.baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    // A start is only accepted once the line has been seen idle high
                    if (rx_sync_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START;
                        tick_d  = TICK_HALF;
                    end
                end
                START: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TW'(1);
                    end else if (!rx_sync_q) begin
                        state_d = DATA;
                        tick_d  = TICK_FULL;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TW'(1);
                    end else begin
                        shift_d[bit_q] = rx_sync_q;
                        tick_d         = TICK_FULL;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TW'(1);
                    end else begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed
                        state_d = IDLE;
                        if (rx_sync_q) begin
                            message_d = shift_q;
                            valid_d   = 1'b1;
                            armed_d   = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            armed_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.message     = message_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
